// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-bank arbiter.
// Port ids double as bit positions in the two-bit request vector.
package regfile_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef logic port_id_t;
    localparam port_id_t HOST = 1'b0;
    localparam port_id_t CORE = 1'b1;

    localparam logic [31:0] DEF_RST_VAL = 32'h0302_0196;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-way round-robin picker: the port that did not win last time wins a tie.
// last_q moves only when the caller signals that the pick was actually taken.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output port_id_t   win_o,
    output logic       any_o
);

    port_id_t last_q;

    always_comb begin
        if (req_i[HOST] && req_i[CORE]) win_o = ~last_q;
        else if (req_i[CORE])           win_o = CORE;
        else                            win_o = HOST;
    end

    assign any_o = |req_i;

    // Starting at CORE lets the host win the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_q <= CORE;
        else if (take_i) last_q <= win_o;
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Register bank shared by the host and core ports: one access per three cycles
// (IDLE -> ACCESS -> RESP), round-robin on contention, whole bank exported flat.
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter int                   NREGS   = 4,
    parameter int                   AW      = 2,
    parameter int                   DW      = 8,
    parameter logic [NREGS*DW-1:0]  RST_VAL = (NREGS*DW)'(DEF_RST_VAL)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [AW-1:0]       host_addr,
    input  logic [DW-1:0]       host_wdata,
    output logic                host_gnt,
    output logic                host_rvalid,
    output logic [DW-1:0]       host_rdata,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [AW-1:0]       core_addr,
    input  logic [DW-1:0]       core_wdata,
    output logic                core_gnt,
    output logic                core_rvalid,
    output logic [DW-1:0]       core_rdata,
    output logic                addr_err,
    output logic [NREGS*DW-1:0] regs_flat
);

    state_t         state_q, state_d;
    port_id_t       win_q;
    logic           we_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic [DW-1:0]  bank_q [NREGS];
    logic [DW-1:0]  host_rdata_q, core_rdata_q;

    port_id_t       win;
    logic           any_req, take, addr_ok;
    logic [DW-1:0]  rd_word;

    assign take = (state_q == IDLE) && any_req;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_i  ({core_req, host_req}),
        .take_i (take),
        .win_o  (win),
        .any_o  (any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are frozen at grant time; the requester may change them afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q   <= CORE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            win_q   <= win;
            we_q    <= (win == HOST) ? host_we    : core_we;
            addr_q  <= (win == HOST) ? host_addr  : core_addr;
            wdata_q <= (win == HOST) ? host_wdata : core_wdata;
        end
    end

    assign addr_ok = int'(addr_q) < NREGS;
    assign rd_word = addr_ok ? bank_q[addr_q] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) bank_q[i] <= RST_VAL[i*DW +: DW];
        end else if (state_q == ACCESS && we_q && addr_ok) begin
            bank_q[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_rdata_q <= '0;
            core_rdata_q <= '0;
        end else if (state_q == ACCESS && !we_q) begin
            if (win_q == HOST) host_rdata_q <= rd_word;
            else               core_rdata_q <= rd_word;
        end
    end

    always_comb begin
        host_gnt    = 1'b0;
        core_gnt    = 1'b0;
        host_rvalid = 1'b0;
        core_rvalid = 1'b0;
        addr_err    = 1'b0;
        if (state_q == ACCESS) begin
            host_gnt = (win_q == HOST);
            core_gnt = (win_q == CORE);
            addr_err = !addr_ok;
        end
        if (state_q == RESP && !we_q) begin
            host_rvalid = (win_q == HOST);
            core_rvalid = (win_q == CORE);
        end
    end

    assign host_rdata = host_rdata_q;
    assign core_rdata = core_rdata_q;

    for (genvar i = 0; i < NREGS; i++) begin : g_flat
        assign regs_flat[i*DW +: DW] = bank_q[i];
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: a 4-register instance checked through a read
// scoreboard, plus a 3-register instance sharing the same stimulus for range errors.
module tb_regfile_arbiter;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_req = 0, host_we = 0, core_req = 0, core_we = 0;
    logic [1:0]  host_addr = 0, core_addr = 0;
    logic [7:0]  host_wdata = 0, core_wdata = 0;

    logic        host_gnt, host_rvalid, core_gnt, core_rvalid, addr_err;
    logic [7:0]  host_rdata, core_rdata;
    logic [31:0] regs_flat;

    logic        h3_gnt, h3_rvalid, c3_gnt, c3_rvalid, err3;
    logic [7:0]  h3_rdata, c3_rdata;
    logic [23:0] flat3;

    typedef struct { logic p; logic [7:0] d; } rd_exp_t;
    rd_exp_t sb[$];

    int         npass = 0, ntot = 0;
    logic [7:0] m4 [4];
    logic [7:0] m3 [3];

    always #5 clk = ~clk;

    regfile_arbiter dut (
        .clk(clk), .rst(rst),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .addr_err(addr_err), .regs_flat(regs_flat)
    );

    regfile_arbiter #(.NREGS(3), .RST_VAL(24'h020196)) dut3 (
        .clk(clk), .rst(rst),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(h3_gnt), .host_rvalid(h3_rvalid), .host_rdata(h3_rdata),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(c3_gnt), .core_rvalid(c3_rvalid), .core_rdata(c3_rdata),
        .addr_err(err3), .regs_flat(flat3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] flat4m();
        return {m4[3], m4[2], m4[1], m4[0]};
    endfunction

    function automatic logic [23:0] flat3m();
        return {m3[2], m3[1], m3[0]};
    endfunction

    task automatic model_reset();
        m4[0] = 8'h96; m4[1] = 8'h01; m4[2] = 8'h02; m4[3] = 8'h03;
        m3[0] = 8'h96; m3[1] = 8'h01; m3[2] = 8'h02;
    endtask

    task automatic drive(input logic p, input logic r, input logic we,
                         input logic [1:0] a, input logic [7:0] wd);
        if (p == HOST) begin
            host_req = r; host_we = we; host_addr = a; host_wdata = wd;
        end else begin
            core_req = r; core_we = we; core_addr = a; core_wdata = wd;
        end
    endtask

    // Starts #1 after an edge with the DUT in IDLE; ends the same way.
    task automatic access(input logic p, input logic we, input logic [1:0] a,
                          input logic [7:0] wd, input logic [7:0] wd_late);
        if (!we) sb.push_back('{p, m4[a]});
        drive(p, 1'b1, we, a, wd);
        @(posedge clk); #1;
        chk("gnt", (p == HOST) ? host_gnt : core_gnt, 1);
        chk("gnt_other", (p == HOST) ? core_gnt : host_gnt, 0);
        chk("addr_err", addr_err, 0);
        chk("addr_err3", err3, (a >= 2'd3));
        drive(p, 1'b1, we, a, wd_late);
        if (we) begin
            m4[a] = wd;
            if (a < 2'd3) m3[a] = wd;
        end
        @(posedge clk); #1;
        chk("rvalid", (p == HOST) ? host_rvalid : core_rvalid, !we);
        chk("addr_err3_pulse", err3, 0);
        chk("regs_flat", regs_flat, flat4m());
        chk("regs_flat3", flat3, flat3m());
        if (!we) chk("rdata3", (p == HOST) ? h3_rdata : c3_rdata, (a < 2'd3) ? m3[a] : 8'h00);
        drive(p, 1'b0, 1'b0, 2'd0, 8'h00);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (host_gnt || core_gnt) chk("gnt_exclusive", host_gnt & core_gnt, 0);
        if (host_rvalid || core_rvalid) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                rd_exp_t e;
                e = sb.pop_front();
                chk("rvalid_port", core_rvalid, e.p);
                chk("rvalid_exclusive", host_rvalid & core_rvalid, 0);
                chk("rdata", (e.p == HOST) ? host_rdata : core_rdata, e.d);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", {host_gnt, core_gnt, h3_gnt, c3_gnt}, 0);
        chk("rst_rvalid", {host_rvalid, core_rvalid}, 0);
        chk("rst_rdata", {host_rdata, core_rdata}, 0);
        chk("rst_addr_err", {addr_err, err3}, 0);
        chk("rst_flat", regs_flat, 32'h03020196);
        chk("rst_flat3", flat3, 24'h020196);
        rst = 1'b0;
        @(posedge clk); #1;

        // Host read, then write/read-back across ports.
        access(HOST, 1'b0, 2'd0, 8'h00, 8'h00);
        access(HOST, 1'b1, 2'd2, 8'hA5, 8'hA5);
        chk("flat_byte2", regs_flat[23:16], 8'hA5);
        access(CORE, 1'b0, 2'd2, 8'h00, 8'h00);

        // Four simultaneous requests: last winner is CORE, so HOST, CORE, HOST, CORE.
        for (int i = 0; i < 4; i++) begin
            logic w;
            w = (i % 2 == 0) ? HOST : CORE;
            sb.push_back('{w, (w == HOST) ? m4[0] : m4[1]});
            drive(HOST, 1'b1, 1'b0, 2'd0, 8'h00);
            drive(CORE, 1'b1, 1'b0, 2'd1, 8'h00);
            @(posedge clk); #1;
            chk("rr_host_gnt", host_gnt, (w == HOST));
            chk("rr_core_gnt", core_gnt, (w == CORE));
            @(posedge clk); #1;
            drive(HOST, 1'b0, 1'b0, 2'd0, 8'h00);
            drive(CORE, 1'b0, 1'b0, 2'd0, 8'h00);
            @(posedge clk); #1;
        end

        // Address 3 is out of range only for the 3-register instance.
        access(CORE, 1'b1, 2'd3, 8'h5A, 8'h5A);
        access(CORE, 1'b0, 2'd3, 8'h00, 8'h00);

        // Reset during ACCESS of a host write: write lost, no response.
        drive(HOST, 1'b1, 1'b1, 2'd1, 8'h77);
        @(posedge clk); #1;
        chk("pre_rst_gnt", host_gnt, 1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_gnt", host_gnt, 0);
        chk("midrst_flat", regs_flat, 32'h03020196);
        chk("midrst_rdata", {host_rdata, core_rdata}, 0);
        drive(HOST, 1'b0, 1'b0, 2'd0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_flat", regs_flat, 32'h03020196);
        access(HOST, 1'b0, 2'd1, 8'h00, 8'h00);

        // Write data changed after grant: the latched value lands.
        access(HOST, 1'b1, 2'd0, 8'h3C, 8'hC3);
        access(CORE, 1'b0, 2'd0, 8'h00, 8'h00);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
